ara_pe_req_acceptor: RTL and testbench



---
 rtl/ara_pkg.sv | 54 +++++
 rtl/ara_pe_req_acceptor.sv | 145 ++++++++++++++
 tb/tb_ara_pe_req_acceptor.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ara_pkg.sv
// ============================================================================
//  Module      : ara_pkg
//  Description : Shared vector-instruction types for the sequencer/PE link.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ara_pkg;

    localparam int unsigned NrVInsn = 8;

    typedef logic [$clog2(NrVInsn)-1:0] vid_t;

    typedef enum logic [2:0] {
        VFU_Alu,
        VFU_MFpu,
        VFU_SlideUnit,
        VFU_MaskUnit,
        VFU_LoadUnit,
        VFU_StoreUnit,
        VFU_None
    } vfu_e;

    typedef enum logic [3:0] {
        VADD,
        VSUB,
        VMUL,
        VLE,
        VSE,
        VSLIDEUP,
        VMAND
    } ara_op_e;

    typedef struct packed {
        vid_t               id;
        ara_op_e            op;
        vfu_e               vfu;
        logic               vm;
        logic [4:0]         vs1;
        logic [4:0]         vs2;
        logic [4:0]         vd;
        logic [NrVInsn-1:0] hazard_vs1;
        logic [NrVInsn-1:0] hazard_vs2;
        logic [NrVInsn-1:0] hazard_vm;
        logic [NrVInsn-1:0] hazard_vd;
    } pe_req_t;

    typedef struct packed {
        logic [NrVInsn-1:0] vinsn_done;
    } pe_resp_t;

endpackage

`default_nettype wire

// File: rtl/ara_pe_req_acceptor.sv
// ============================================================================
//  Module      : ara_pe_req_acceptor
//  Description : Filters broadcast PE requests, queues them in order, releases
//                each once its hazards clear and reports completions.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ara_pe_req_acceptor
    import ara_pkg::*;
#(
    parameter vfu_e        Vfu           = VFU_Alu,
    parameter bit          IsMaskUnit    = 1'b0,
    parameter int unsigned QueueDepth    = 4,
    parameter bit          ChainOperands = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  pe_req_t            pe_req_i,
    input  logic               pe_req_valid_i,
    output logic               pe_req_ready_o,
    input  logic [NrVInsn-1:0] pe_vinsn_running_i,
    output pe_resp_t           pe_resp_o,
    output pe_req_t            insn_o,
    output logic               insn_valid_o,
    input  logic               insn_ready_i,
    input  logic               unit_done_i,
    input  vid_t               unit_done_id_i
);

    localparam int unsigned PtrW = $clog2(QueueDepth);
    localparam int unsigned CntW = $clog2(QueueDepth + 1);

    pe_req_t                queue_q [QueueDepth];
    logic [QueueDepth-1:0]  slot_valid_q;
    logic [PtrW-1:0]        rd_ptr_q;
    logic [PtrW-1:0]        wr_ptr_q;
    logic [CntW-1:0]        count_q;
    logic [NrVInsn-1:0]     outstanding_q;
    pe_resp_t               resp_q;

    pe_req_t            incoming;
    pe_req_t            head;
    logic               in_queue;
    logic               relevant;
    logic               duplicate;
    logic               push;
    logic               pop;
    logic               done_ok;
    logic [NrVInsn-1:0] gate;

    always_comb begin
        in_queue = 1'b0;
        for (int unsigned i = 0; i < QueueDepth; i++) begin
            if (slot_valid_q[i] && (queue_q[i].id == pe_req_i.id)) begin
                in_queue = 1'b1;
            end
        end
    end

    assign relevant       = (pe_req_i.vfu == Vfu) || (IsMaskUnit && !pe_req_i.vm);
    assign duplicate      = in_queue || outstanding_q[pe_req_i.id];
    assign pe_req_ready_o = (count_q < CntW'(QueueDepth));
    assign push           = pe_req_valid_i && pe_req_ready_o && relevant && !duplicate;

    // Hazards seen by the unit are always filtered by what is still running now
    always_comb begin
        incoming            = pe_req_i;
        incoming.hazard_vs1 = pe_req_i.hazard_vs1 & pe_vinsn_running_i;
        incoming.hazard_vs2 = pe_req_i.hazard_vs2 & pe_vinsn_running_i;
        incoming.hazard_vm  = pe_req_i.hazard_vm  & pe_vinsn_running_i;
        incoming.hazard_vd  = pe_req_i.hazard_vd  & pe_vinsn_running_i;

        head            = queue_q[rd_ptr_q];
        insn_o          = head;
        insn_o.hazard_vs1 = head.hazard_vs1 & pe_vinsn_running_i;
        insn_o.hazard_vs2 = head.hazard_vs2 & pe_vinsn_running_i;
        insn_o.hazard_vm  = head.hazard_vm  & pe_vinsn_running_i;
        insn_o.hazard_vd  = head.hazard_vd  & pe_vinsn_running_i;
    end

    assign gate = ChainOperands ? insn_o.hazard_vd
                                : (insn_o.hazard_vd | insn_o.hazard_vs1 |
                                   insn_o.hazard_vs2 | insn_o.hazard_vm);

    assign insn_valid_o = (count_q != '0) && (gate == '0);
    assign pop          = insn_valid_o && insn_ready_i;
    assign done_ok      = unit_done_i && outstanding_q[unit_done_id_i];
    assign pe_resp_o    = resp_q;

    // Payload needs no reset: slot_valid_q qualifies every use of it
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < QueueDepth; i++) begin
            if (push && (wr_ptr_q == PtrW'(i))) begin
                queue_q[i] <= incoming;
            end else if (slot_valid_q[i]) begin
                queue_q[i].hazard_vs1 <= queue_q[i].hazard_vs1 & pe_vinsn_running_i;
                queue_q[i].hazard_vs2 <= queue_q[i].hazard_vs2 & pe_vinsn_running_i;
                queue_q[i].hazard_vm  <= queue_q[i].hazard_vm  & pe_vinsn_running_i;
                queue_q[i].hazard_vd  <= queue_q[i].hazard_vd  & pe_vinsn_running_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid_q  <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            resp_q        <= '0;
        end else begin
            if (push) begin
                slot_valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q <= (wr_ptr_q == PtrW'(QueueDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                slot_valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q <= (rd_ptr_q == PtrW'(QueueDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            outstanding_q <= (outstanding_q &
                              ~(done_ok ? (NrVInsn'(1) << unit_done_id_i) : '0)) |
                             (pop ? (NrVInsn'(1) << head.id) : '0);

            resp_q.vinsn_done <= done_ok ? (NrVInsn'(1) << unit_done_id_i) : '0;
        end
    end

`ifndef SYNTHESIS
    done_is_outstanding: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        unit_done_i |-> outstanding_q[unit_done_id_i]
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_ara_pe_req_acceptor.sv
// ============================================================================
//  Module      : tb_ara_pe_req_acceptor
//  Description : Self-checking bench for ara_pe_req_acceptor (ALU + mask unit).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ara_pe_req_acceptor;
    import ara_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    pe_req_t            req;
    logic               req_valid;
    logic [NrVInsn-1:0] running;
    logic               insn_ready;
    logic               unit_done;
    vid_t               done_id;

    logic               req_ready;
    pe_resp_t           resp;
    pe_req_t            insn;
    logic               insn_valid;

    logic               req_ready_m;
    pe_resp_t           resp_m;
    pe_req_t            insn_m;
    logic               insn_valid_m;
    logic               insn_ready_m = 1'b1;
    logic               unit_done_m  = 1'b0;
    vid_t               done_id_m    = '0;

    int total = 0;
    int bad   = 0;
    vid_t exp_q[$];
    vid_t exp_qm[$];
    logic [NrVInsn-1:0] exp_resp;

    always #5 clk = ~clk;

    ara_pe_req_acceptor #(.Vfu(VFU_Alu), .IsMaskUnit(1'b0), .QueueDepth(4), .ChainOperands(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .pe_req_i(req), .pe_req_valid_i(req_valid),
        .pe_req_ready_o(req_ready), .pe_vinsn_running_i(running), .pe_resp_o(resp),
        .insn_o(insn), .insn_valid_o(insn_valid), .insn_ready_i(insn_ready),
        .unit_done_i(unit_done), .unit_done_id_i(done_id)
    );

    ara_pe_req_acceptor #(.Vfu(VFU_MaskUnit), .IsMaskUnit(1'b1), .QueueDepth(4), .ChainOperands(1'b1)) dut_mask (
        .clk_i(clk), .rst_ni(rst_n), .pe_req_i(req), .pe_req_valid_i(req_valid),
        .pe_req_ready_o(req_ready_m), .pe_vinsn_running_i(running), .pe_resp_o(resp_m),
        .insn_o(insn_m), .insn_valid_o(insn_valid_m), .insn_ready_i(insn_ready_m),
        .unit_done_i(unit_done_m), .unit_done_id_i(done_id_m)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic pe_req_t mk(input ara_op_e op, input vfu_e vfu, input logic vm, input int id,
                                   input logic [NrVInsn-1:0] hvd, input logic [NrVInsn-1:0] hvs1);
        pe_req_t r;
        r            = '0;
        r.op         = op;
        r.vfu        = vfu;
        r.vm         = vm;
        r.id         = vid_t'(id);
        r.hazard_vd  = hvd;
        r.hazard_vs1 = hvs1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic done_pulse(input int id);
        unit_done = 1'b1;
        done_id   = vid_t'(id);
        tick();
        unit_done = 1'b0;
    endtask

    // Completion model: a done driven in cycle t shows up as a one-hot in t+1
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_resp <= '0;
        else        exp_resp <= unit_done ? (NrVInsn'(1) << done_id) : '0;
    end

    // Scoreboard: every handshake on either instance pops the next expected id
    always @(negedge clk) begin
        if (rst_n) begin
            if (insn_valid && insn_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_issue: got id %0d expected none", insn.id);
                end else begin
                    check("issue_id", 32'(insn.id), 32'(exp_q.pop_front()));
                end
            end
            if (insn_valid_m && insn_ready_m) begin
                if (exp_qm.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_mask_issue: got id %0d expected none", insn_m.id);
                end else begin
                    check("mask_issue_id", 32'(insn_m.id), 32'(exp_qm.pop_front()));
                end
            end
            check("vinsn_done", 32'(resp.vinsn_done), 32'(exp_resp));
        end
    end

    typedef struct {
        ara_op_e op;
        vfu_e    vfu;
        logic    vm;
        int      id;
        logic    alu;
        logic    mask;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{VADD,  VFU_Alu,       1'b1, 1, 1'b1, 1'b0};
        vecs[1] = '{VLE,   VFU_LoadUnit,  1'b1, 2, 1'b0, 1'b0};
        vecs[2] = '{VADD,  VFU_Alu,       1'b0, 4, 1'b1, 1'b1};
        vecs[3] = '{VSE,   VFU_StoreUnit, 1'b0, 6, 1'b0, 1'b1};
        vecs[4] = '{VMAND, VFU_MaskUnit,  1'b1, 7, 1'b0, 1'b1};
        vecs[5] = '{VSUB,  VFU_Alu,       1'b1, 0, 1'b1, 1'b0};

        rst_n      = 1'b1;
        req        = '0;
        req_valid  = 1'b0;
        running    = '0;
        insn_ready = 1'b0;
        unit_done  = 1'b0;
        done_id    = '0;
        #2 rst_n   = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_insn_valid", 32'(insn_valid), 32'd0);
        check("rst_resp", 32'(resp), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic round trip
        insn_ready = 1'b1;
        req = mk(VADD, VFU_Alu, 1'b1, 3, '0, '0);
        req_valid = 1'b1;
        exp_q.push_back(vid_t'(3));
        #1 check("no_bypass", 32'(insn_valid), 32'd0);
        tick();
        req_valid = 1'b0;
        #1 check("rt_valid", 32'(insn_valid), 32'd1);
        tick();
        done_pulse(3);
        check("rt_done", 32'(resp.vinsn_done), 32'h08);
        tick();
        check("rt_done_once", 32'(resp.vinsn_done), 32'h00);

        // Relevance table across the ALU and mask-unit instances
        for (int i = 0; i < 6; i++) begin
            req = mk(vecs[i].op, vecs[i].vfu, vecs[i].vm, vecs[i].id, '0, '0);
            req_valid = 1'b1;
            if (vecs[i].alu)  exp_q.push_back(vid_t'(vecs[i].id));
            if (vecs[i].mask) exp_qm.push_back(vid_t'(vecs[i].id));
            tick();
            req_valid = 1'b0;
            #1;
            check("tbl_alu_valid", 32'(insn_valid), 32'(vecs[i].alu));
            check("tbl_mask_valid", 32'(insn_valid_m), 32'(vecs[i].mask));
            tick();
            if (vecs[i].alu) done_pulse(vecs[i].id);
            else             tick();
            tick();
        end

        // Same request held for four cycles
        req = mk(VADD, VFU_Alu, 1'b1, 5, '0, '0);
        req_valid = 1'b1;
        exp_q.push_back(vid_t'(5));
        repeat (4) tick();
        req_valid = 1'b0;
        #1 check("dup_empty", 32'(insn_valid), 32'd0);
        done_pulse(5);
        tick();

        // Fill, overflow attempt, pop, wrap
        insn_ready = 1'b0;
        for (int id = 0; id < 4; id++) begin
            req = mk(VADD, VFU_Alu, 1'b1, id, '0, '0);
            req_valid = 1'b1;
            #1 check("full_ready_pre", 32'(req_ready), 32'd1);
            exp_q.push_back(vid_t'(id));
            tick();
        end
        req = mk(VADD, VFU_Alu, 1'b1, 4, '0, '0);
        #1;
        check("full_ready_low", 32'(req_ready), 32'd0);
        check("full_head_valid", 32'(insn_valid), 32'd1);
        tick();
        insn_ready = 1'b1;
        #1 check("no_passthru", 32'(req_ready), 32'd0);
        tick();
        #1 check("ready_after_pop", 32'(req_ready), 32'd1);
        exp_q.push_back(vid_t'(4));
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        check("drain_empty", 32'(insn_valid), 32'd0);
        for (int id = 0; id < 5; id++) done_pulse(id);
        tick();

        // WAW gating; a pending vs1 hazard must not block with chaining
        running = 8'b0000_0110;
        req = mk(VADD, VFU_Alu, 1'b1, 6, 8'b0000_0100, 8'b0000_0010);
        req_valid = 1'b1;
        exp_q.push_back(vid_t'(6));
        tick();
        req_valid = 1'b0;
        #1 check("waw_blocked", 32'(insn_valid), 32'd0);
        tick();
        check("waw_blocked2", 32'(insn_valid), 32'd0);
        running = 8'b0000_0010;
        #1;
        check("waw_issue", 32'(insn_valid), 32'd1);
        check("vs1_masked", 32'(insn.hazard_vs1), 32'h02);
        check("vd_masked", 32'(insn.hazard_vd), 32'h00);
        tick();
        running = '0;
        done_pulse(6);
        tick();

        // Hazards are masked on write and refreshed while queued
        insn_ready = 1'b0;
        req = mk(VADD, VFU_Alu, 1'b1, 1, 8'b0000_1000, '0);
        req_valid = 1'b1;
        exp_q.push_back(vid_t'(1));
        tick();
        req_valid = 1'b0;
        running = 8'b0000_1000;
        #1 check("store_masked", 32'(insn_valid), 32'd1);
        insn_ready = 1'b1;
        tick();
        insn_ready = 1'b0;
        done_pulse(1);
        req = mk(VADD, VFU_Alu, 1'b1, 2, 8'b0000_1000, '0);
        req_valid = 1'b1;
        exp_q.push_back(vid_t'(2));
        tick();
        req_valid = 1'b0;
        #1 check("refresh_blocked", 32'(insn_valid), 32'd0);
        running = '0;
        tick();
        running = 8'b0000_1000;
        #1 check("refresh_cleared", 32'(insn_valid), 32'd1);
        insn_ready = 1'b1;
        tick();
        insn_ready = 1'b0;
        running = '0;
        done_pulse(2);
        tick();

        // Reset with one outstanding and two queued
        insn_ready = 1'b1;
        req = mk(VADD, VFU_Alu, 1'b1, 1, '0, '0);
        req_valid = 1'b1;
        exp_q.push_back(vid_t'(1));
        tick();
        req_valid = 1'b0;
        tick();
        insn_ready = 1'b0;
        req = mk(VADD, VFU_Alu, 1'b1, 2, '0, '0);
        req_valid = 1'b1;
        tick();
        req = mk(VADD, VFU_Alu, 1'b1, 3, '0, '0);
        tick();
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mrst_ready", 32'(req_ready), 32'd1);
        check("mrst_insn_valid", 32'(insn_valid), 32'd0);
        check("mrst_resp", 32'(resp), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        insn_ready = 1'b1;
        req = mk(VADD, VFU_Alu, 1'b1, 1, '0, '0);
        req_valid = 1'b1;
        exp_q.push_back(vid_t'(1));
        tick();
        req_valid = 1'b0;
        #1 check("post_rst_accept", 32'(insn_valid), 32'd1);
        tick();
        done_pulse(1);
        tick();
        tick();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("sb_mask_empty", 32'(exp_qm.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
